matmul_mem_bridge: RTL

Memory-side partner of the matrix-multiplication core: it services the core's `mem_operation`/`addr_o`/`mem_opdone` request port from one single-port synchronous scratchpad SRAM. It also exposes a Wishbone-classic slave port so the host CPU can load the parameter words and operands A and B, and read back result C. Both requesters share the SRAM through a two-way round-robin arbiter with one transaction in flight at a time.

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/matmul_mem_bridge.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared opcodes, bridge state encoding and memory-map constants for the
// matrix-multiply core and its scratchpad bridge.
package matmul_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b11;

    localparam int MATMUL_PARAM_WORDS = 4;

    // Grant vector bit positions shared by the arbiter and the bridge.
    localparam int GNT_CORE = 0;
    localparam int GNT_HOST = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_ACK  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_ACK  = 2'd3
    } bridge_state_t;

    function automatic logic is_mem_req(input logic [1:0] op);
        return (op == MEM_READ) || (op == MEM_WRITE);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: core on bit GNT_CORE, host on bit GNT_HOST.
// Priority only flips when a contested request is actually granted.
module rr_arbiter2
    import matmul_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_host;
    logic contested;

    assign contested = req[GNT_CORE] & req[GNT_HOST];

    always_comb begin
        gnt = req;
        if (contested) begin
            gnt = '0;
            if (last_host) begin
                gnt[GNT_CORE] = 1'b1;
            end else begin
                gnt[GNT_HOST] = 1'b1;
            end
        end
    end

    // last_host cleared at reset so the host wins the first contest.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_host <= 1'b0;
        end else if (advance && contested) begin
            last_host <= gnt[GNT_HOST];
        end
    end

endmodule

// File: rtl/matmul_mem_bridge.sv
// Shares one single-port scratchpad SRAM between the matmul core request port
// and a Wishbone-classic host slave, one transaction in flight at a time.
module matmul_mem_bridge
    import matmul_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [1:0]        core_op,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_opdone,

    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,

    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,

    output logic              err
);

    bridge_state_t state;

    logic win_host;
    logic win_write;
    logic win_oor;

    logic core_req;
    logic host_req;
    logic advance;
    logic [1:0] gnt;

    logic [31:0] core_hi;
    logic core_oor;
    logic unused_adr;

    logic              sel_write;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign core_req = is_mem_req(core_op);
    assign host_req = wbs_cyc_i & wbs_stb_i;

    // The cycle carrying done/ack is skipped: requesters only drop or change
    // their request on that edge, so granting then would replay a stale one.
    assign advance = (state == ST_IDLE) && !core_opdone && !wbs_ack_o
                     && (core_req || host_req);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({host_req, core_req}),
        .advance (advance),
        .gnt     (gnt)
    );

    assign core_hi    = core_addr >> ADDR_W;
    assign core_oor   = |core_hi;
    assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    assign sel_write = gnt[GNT_HOST] ? wbs_we_i : (core_op == MEM_WRITE);
    assign sel_oor   = gnt[GNT_CORE] & core_oor;
    assign sel_addr  = gnt[GNT_HOST] ? wbs_adr_i[ADDR_W+1:2] : core_addr[ADDR_W-1:0];
    assign sel_data  = gnt[GNT_HOST] ? DATA_W'(wbs_dat_i) : core_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            win_host    <= 1'b0;
            win_write   <= 1'b0;
            win_oor     <= 1'b0;
            core_rdata  <= '0;
            core_opdone <= 1'b0;
            wbs_dat_o   <= '0;
            wbs_ack_o   <= 1'b0;
            sram_csb    <= 1'b1;
            sram_web    <= 1'b1;
            sram_addr   <= '0;
            sram_din    <= '0;
            err         <= 1'b0;
        end else begin
            core_opdone <= 1'b0;
            wbs_ack_o   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        win_host  <= gnt[GNT_HOST];
                        win_write <= sel_write;
                        win_oor   <= sel_oor;
                        // Out-of-range core accesses still complete on time, just without the SRAM.
                        if (sel_oor) begin
                            err <= 1'b1;
                        end else begin
                            sram_csb  <= 1'b0;
                            sram_web  <= !sel_write;
                            sram_addr <= sel_addr;
                            sram_din  <= sel_data;
                        end
                        state <= sel_write ? ST_WR_ACK : ST_RD_WAIT;
                    end
                end

                ST_WR_ACK: begin
                    sram_csb <= 1'b1;
                    sram_web <= 1'b1;
                    if (win_host) begin
                        wbs_ack_o <= 1'b1;
                    end else begin
                        core_opdone <= 1'b1;
                    end
                    state <= ST_IDLE;
                end

                ST_RD_WAIT: begin
                    sram_csb <= 1'b1;
                    sram_web <= 1'b1;
                    state    <= ST_RD_ACK;
                end

                ST_RD_ACK: begin
                    // sram_dout is valid this cycle; capture it together with the done pulse.
                    if (win_host) begin
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= 32'(sram_dout);
                    end else begin
                        core_opdone <= 1'b1;
                        core_rdata  <= win_oor ? '0 : sram_dout;
                    end
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
